dwt_fir_decim: RTL and testbench

- Parametrised two-band wavelet analysis stage: signed N-tap lowpass and highpass FIR pair sharing one sample delay line, with 2:1 decimation.
- Successor to the fixed 4-tap unsigned filter. Adds signed arithmetic, per-band coefficient sets, round-half-up, saturation, valid/ready handshake with backpressure, and a synchronous frame clear.
- Sits between the sample source and the next decomposition level; instances cascade by feeding lp_out into the next stage's in_data.

---
 rtl/dwt_pkg.sv | 24 ++
 rtl/dwt_mac.sv | 24 ++
 rtl/dwt_fir_decim.sv | 73 +++++++
 tb/tb_dwt_fir_decim.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// dwt_pkg: shared constants and arithmetic helpers for the wavelet analysis stage
package dwt_pkg;
  localparam logic [63:0] LP_HAAR_Q8 = 64'h0000_0000_00B5_00B5;
  localparam logic [63:0] HP_HAAR_Q8 = 64'h0000_0000_FF4B_00B5;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction
  // round half up by dropping frac bits, then clip to a signed ow-bit range
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc, input int frac,
                                                   input int ow, output logic clip);
    logic signed [63:0] r, hi, lo;
    r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    clip = (r > hi) || (r < lo);
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/dwt_mac.sv
// dwt_mac: registered full-precision dot product of the sample window with a constant coefficient set
module dwt_mac import dwt_pkg::*; #(
  parameter int TAPS = 4,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter logic [TAPS*COEF_W-1:0] COEF = '0,
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [TAPS*DATA_W-1:0]  win,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [ACC_W-1:0] sum;
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++)
      sum += ACC_W'($signed(win[k*DATA_W +: DATA_W])) * ACC_W'($signed(COEF[k*COEF_W +: COEF_W]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/dwt_fir_decim.sv
// dwt_fir_decim: two-band signed FIR analysis stage with shared delay line and 2:1 decimation
module dwt_fir_decim import dwt_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS = 4,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W = 20,
  parameter logic [TAPS*COEF_W-1:0] LP_COEF = LP_HAAR_Q8,
  parameter logic [TAPS*COEF_W-1:0] HP_COEF = HP_HAAR_Q8,
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  lp_out,
  output logic [OUT_W-1:0]  hp_out,
  output logic              sat_flag
);
  logic [TAPS-2:0][DATA_W-1:0] x;
  logic [TAPS*DATA_W-1:0] win;
  logic signed [ACC_W-1:0] lp_acc, hp_acc;
  logic [OUT_W-1:0] lp_sat, hp_sat;
  logic en, accept, launch, phase, v1, lp_clip, hp_clip;
  // the MACs see the window including the incoming sample so a launch needs no extra cycle
  assign win = {x, in_data};
  assign en = !out_valid || out_ready;
  assign in_ready = en && !sync_clr;
  assign accept = in_valid && in_ready;
  assign launch = accept && phase;
  dwt_mac #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF(LP_COEF)) u_lp (
    .clk(clk), .rst_n(rst_n), .en(en), .win(win), .acc(lp_acc));
  dwt_mac #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF(HP_COEF)) u_hp (
    .clk(clk), .rst_n(rst_n), .en(en), .win(win), .acc(hp_acc));
  always_comb begin
    lp_sat = OUT_W'(round_sat(64'(lp_acc), FRAC_BITS, OUT_W, lp_clip));
    hp_sat = OUT_W'(round_sat(64'(hp_acc), FRAC_BITS, OUT_W, hp_clip));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      phase <= 1'b0;
      v1 <= 1'b0;
      out_valid <= 1'b0;
      lp_out <= '0;
      hp_out <= '0;
      sat_flag <= 1'b0;
    end else if (sync_clr) begin
      x <= '0;
      phase <= 1'b0;
      v1 <= 1'b0;
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (accept) begin
        x <= win[(TAPS-1)*DATA_W-1:0];
        phase <= !phase;
      end
      if (en) begin
        v1 <= launch;
        out_valid <= v1;
        sat_flag <= sat_flag | (v1 & (lp_clip | hp_clip));
        if (v1) begin
          lp_out <= lp_sat;
          hp_out <= hp_sat;
        end
      end
    end
endmodule

// File: tb/tb_dwt_fir_decim.sv
// tb_dwt_fir_decim: three coefficient variants driven in lockstep against a convolution/decimation model
module tb_dwt_fir_decim;
  logic clk = 0, rst_n, sync_clr, in_valid, out_ready;
  logic [15:0] in_data;
  logic ir[3], ov[3], sat[3];
  logic signed [19:0] lp_o[3], hp_o[3];
  int total = 0, bad = 0, pulses = 0, nacc = 0, acc_cnt = 0;
  int cf[3][2][4];
  int hist[$];
  logic [122:0] expq[$];
  logic [2:0] msat;
  longint out_log1[$];
  always #5 clk = ~clk;

  dwt_fir_decim u0 (.clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .lp_out(lp_o[0]), .hp_out(hp_o[0]), .sat_flag(sat[0]));
  dwt_fir_decim #(.LP_COEF(64'h0000_0000_0000_0001)) u1 (.clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .lp_out(lp_o[1]), .hp_out(hp_o[1]), .sat_flag(sat[1]));
  dwt_fir_decim #(.LP_COEF(64'h7FFF_7FFF_7FFF_7FFF), .HP_COEF(64'h7FFF_7FFF_7FFF_7FFF)) u2 (.clk(clk),
    .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .lp_out(lp_o[2]), .hp_out(hp_o[2]), .sat_flag(sat[2]));

  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_out(int d, int b, output logic clip);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < hist.size(); k++) acc += longint'(hist[k]) * cf[d][b][k];
    r = longint'($floor(real'(acc) / 256.0 + 0.5));
    clip = r > 524287 || r < -524288;
    return r > 524287 ? 524287 : r < -524288 ? -524288 : r;
  endfunction

  function automatic void model_accept(int v);
    logic [122:0] e;
    logic clip;
    longint r;
    hist.push_front(v);
    if (hist.size() > 4) void'(hist.pop_back());
    nacc++;
    acc_cnt++;
    if (nacc % 2 == 0) begin
      e = '0;
      for (int d = 0; d < 3; d++)
        for (int b = 0; b < 2; b++) begin
          r = model_out(d, b, clip);
          e[(d*2+b)*20 +: 20] = 20'(r);
          msat[d] = msat[d] | clip;
        end
      e[122:120] = msat;
      expq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hist.delete(); expq.delete(); nacc = 0; msat = '0;
    end else begin
      if (ov[0] && out_ready) begin
        pulses++;
        if (expq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          logic [122:0] e;
          e = expq.pop_front();
          for (int d = 0; d < 3; d++) begin
            chk($sformatf("lp%0d", d), lp_o[d], $signed(e[(d*2)*20 +: 20]));
            chk($sformatf("hp%0d", d), hp_o[d], $signed(e[(d*2+1)*20 +: 20]));
            chk($sformatf("sat%0d", d), sat[d], e[120+d]);
          end
          out_log1.push_back(lp_o[1]);
        end
      end
      if (sync_clr) begin
        hist.delete(); expq.delete(); nacc = 0; msat = '0;
      end else if (in_valid && ir[0]) model_accept(int'($signed(in_data)));
    end
  end

  task automatic set(bit v, logic [15:0] d, bit r, bit c);
    in_valid = v; in_data = d; out_ready = r; sync_clr = c;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic impulse(bit do_clr);
    int p0;
    if (do_clr) begin set(0, 0, 1, 1); step(); end
    p0 = pulses;
    set(1, 16'd256, 1, 0); step();
    set(1, 0, 1, 0); step();
    chk("imp_early", ov[0], 0);
    step();
    chk("imp_valid1", ov[0], 1); chk("imp_lp1", lp_o[0], 181); chk("imp_hp1", hp_o[0], -181);
    step();
    chk("imp_gap", ov[0], 0);
    set(0, 0, 1, 0); step();
    chk("imp_valid2", ov[0], 1); chk("imp_lp2", lp_o[0], 0); chk("imp_hp2", hp_o[0], 0);
    step(); step();
    chk("imp_pulses", pulses - p0, 2);
  endtask

  initial begin
    int rv[4] = '{128, 127, -128, -129};
    int rx[4] = '{1, 0, 0, -1};
    logic signed [19:0] hl, hh;
    bit held;
    int p0, cyc;
    cf[0][0] = '{181, 181, 0, 0}; cf[0][1] = '{181, -181, 0, 0};
    cf[1][0] = '{1, 0, 0, 0};     cf[1][1] = '{181, -181, 0, 0};
    cf[2][0] = '{32767, 32767, 32767, 32767}; cf[2][1] = '{32767, 32767, 32767, 32767};
    msat = '0;
    rst_n = 1; set(0, 0, 1, 0);
    #2 rst_n = 0; #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ov", ov[d], 0); chk("rst_lp", lp_o[d], 0); chk("rst_hp", hp_o[d], 0); chk("rst_sat", sat[d], 0);
    end
    #9 rst_n = 1;
    step();
    impulse(1);
    // rounding on the tap0-only variant: phase-1 sample carries the value
    set(0, 0, 1, 1); step();
    out_log1.delete();
    for (int i = 0; i < 4; i++) begin
      set(1, 0, 1, 0); step();
      set(1, 16'(rv[i]), 1, 0); step();
    end
    set(0, 0, 1, 0); step(); step(); step();
    chk("rnd_count", out_log1.size(), 4);
    if (out_log1.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d", i), out_log1[i], rx[i]);
    // saturation
    for (int i = 0; i < 8; i++) begin set(1, 16'h7FFF, 1, 0); step(); end
    set(0, 0, 1, 0); step(); step(); step();
    chk("sat_pos_lp", lp_o[2], 524287); chk("sat_pos_flag", sat[2], 1);
    for (int i = 0; i < 8; i++) begin set(1, 16'h8000, 1, 0); step(); end
    set(0, 0, 1, 0); step(); step(); step();
    chk("sat_neg_lp", lp_o[2], -524288); chk("sat_neg_flag", sat[2], 1);
    // sync_clr after a phase-0 accept, then the impulse again
    set(1, 16'd999, 1, 0); step();
    set(1, 16'd555, 1, 1); #1;
    chk("clr_ready", ir[0], 0);
    step();
    chk("clr_sat", sat[2], 0); chk("clr_ov", ov[0], 0);
    impulse(0);
    // backpressure
    for (int i = 0; i < 4; i++) begin set(1, 16'($urandom), 1, 0); step(); end
    held = 0; hl = 0; hh = 0;
    for (int i = 0; i < 5; i++) begin
      set(1, 16'($urandom), 0, 0); step();
      if (ov[0]) begin
        if (!held) begin held = 1; hl = lp_o[0]; hh = hp_o[0]; end
        chk("bp_ready", ir[0], 0); chk("bp_lp_hold", lp_o[0], hl); chk("bp_hp_hold", hp_o[0], hh);
      end
    end
    chk("bp_stalled", held, 1);
    set(0, 0, 1, 0); step(); step(); step(); step();
    chk("bp_drain", expq.size(), 0);
    // reset while stalled
    set(1, 16'd300, 1, 0); step(); step();
    set(0, 0, 0, 0); step(); step(); step();
    chk("stall_pre", ov[0], 1);
    rst_n = 0; #1;
    chk("mrst_ov", ov[0], 0); chk("mrst_lp", lp_o[0], 0); chk("mrst_hp", hp_o[0], 0);
    step();
    rst_n = 1;
    p0 = pulses;
    set(0, 0, 1, 0); step(); step(); step(); step();
    chk("mrst_no_out", pulses - p0, 0);
    // random traffic
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < 10000 && cyc < 40000) begin
      logic [15:0] d;
      d = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      set($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);
      step();
      cyc++;
    end
    chk("rand_budget", acc_cnt >= 10000, 1);
    set(0, 0, 1, 0); step(); step(); step(); step(); step();
    chk("rand_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
